// File: rtl/inst_fetch_unit_if.sv
// Instruction-fetch handshake between the pc unit, the fetch unit and the RAM byte port.
// The slave modport is the fetch unit's view; master is the pc/RAM side.
interface inst_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  if_output_pc;
  logic [ADDR_WIDTH-1:0] pc_to_getInst;
  logic                  if_gotInst;
  logic [INST_WIDTH-1:0] inst_mem;
  logic                  if_jump;
  logic [7:0]            mem_din;
  logic [ADDR_WIDTH-1:0] mem_a;

  modport slave (
    input  if_output_pc, pc_to_getInst, if_jump, mem_din,
    output if_gotInst, inst_mem, mem_a
  );

  modport master (
    output if_output_pc, pc_to_getInst, if_jump, mem_din,
    input  if_gotInst, inst_mem, mem_a
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch responder: reads four RAM bytes little-endian and returns one instruction with a done pulse.
// Optional direct-mapped instruction cache is compiled in with the ICACHE_EN macro.
module inst_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
`ifdef ICACHE_EN
  , parameter int ICACHE_LINES = 256
`endif
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  inst_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           part_q, part_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  got_q, got_d;
  logic                  restart_q, restart_d;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [INST_WIDTH-1:0]   cdata_q [ICACHE_LINES];
  logic [TAG_W-1:0]        ctag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cvalid_q;
  logic [IDX_W-1:0]        look_idx_s, fill_idx_s;
  logic                    hit_s, fill_s;

  assign look_idx_s = bus.pc_to_getInst[IDX_W+1:2];
  assign fill_idx_s = base_q[IDX_W+1:2];
  // Misaligned addresses never hit, so they can never be served from a line.
  assign hit_s = cvalid_q[look_idx_s]
              && (ctag_q[look_idx_s] == bus.pc_to_getInst[ADDR_WIDTH-1:IDX_W+2])
              && (bus.pc_to_getInst[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cvalid_q <= '0;
    end else if (fill_s) begin
      cvalid_q[fill_idx_s] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && fill_s) begin
      cdata_q[fill_idx_s] <= inst_d;
      ctag_q[fill_idx_s]  <= base_q[ADDR_WIDTH-1:IDX_W+2];
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    mem_a_d   = mem_a_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    inst_d    = inst_q;
    got_d     = 1'b0;
    restart_d = restart_q;
`ifdef ICACHE_EN
    fill_s    = 1'b0;
`endif
    if (!rdy) begin
      // Frozen; a fetch interrupted mid-read is restarted from byte 0 on resume.
      if (state_q == READ) begin
        restart_d = 1'b1;
      end else begin
        restart_d = restart_q;
      end
    end else if (bus.if_jump) begin
      state_d   = IDLE;
      cnt_d     = 2'd0;
      part_d    = 24'd0;
      restart_d = 1'b0;
    end else if (restart_q) begin
      mem_a_d   = base_q;
      cnt_d     = 2'd0;
      part_d    = 24'd0;
      restart_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_output_pc) begin
            base_d = bus.pc_to_getInst;
`ifdef ICACHE_EN
            if (hit_s) begin
              inst_d  = cdata_q[look_idx_s];
              got_d   = 1'b1;
              state_d = HOLD;
            end else begin
              mem_a_d = bus.pc_to_getInst;
              cnt_d   = 2'd0;
              part_d  = 24'd0;
              state_d = READ;
            end
`else
            mem_a_d = bus.pc_to_getInst;
            cnt_d   = 2'd0;
            part_d  = 24'd0;
            state_d = READ;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          case (cnt_q)
            2'd0:    part_d[7:0]   = bus.mem_din;
            2'd1:    part_d[15:8]  = bus.mem_din;
            2'd2:    part_d[23:16] = bus.mem_din;
            default: part_d        = part_q;
          endcase
          if (cnt_q == 2'd3) begin
            inst_d  = {bus.mem_din, part_q};
            got_d   = 1'b1;
            state_d = HOLD;
`ifdef ICACHE_EN
            fill_s  = (base_q[1:0] == 2'b00);
`endif
          end else begin
            mem_a_d = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
            cnt_d   = cnt_q + 2'd1;
          end
        end
        HOLD: begin
          if (!bus.if_output_pc) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      mem_a_q   <= '0;
      cnt_q     <= 2'd0;
      part_q    <= 24'd0;
      inst_q    <= '0;
      got_q     <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      mem_a_q   <= mem_a_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      inst_q    <= inst_d;
      got_q     <= got_d;
      restart_q <= restart_d;
    end
  end

  assign bus.if_gotInst = got_q;
  assign bus.inst_mem   = inst_q;
  assign bus.mem_a      = mem_a_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed sequences, a vector table and a random run against a queue-based model.
// Define ICACHE_EN to exercise the cache build.
module tb_inst_fetch_unit;
  localparam int AW = 32;
  localparam int IW = 32;
`ifdef ICACHE_EN
  localparam int LINES = 256;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic [7:0] ram [4096];
  int errors = 0;
  int checks = 0;

  inst_fetch_unit_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  assign bus.mem_din = ram[bus.mem_a[11:0]];

  inst_fetch_unit #(
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW)
`ifdef ICACHE_EN
    , .ICACHE_LINES(LINES)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: progress of a fetch is the queue of bytes collected so far.
  int         m_mode;  // 0 waiting, 1 collecting bytes, 2 delivered
  logic [31:0] m_base, m_mem_a, m_inst;
  logic        m_got, m_restart;
  logic [7:0]  m_bytes [$];
`ifdef ICACHE_EN
  logic [31:0] mc_addr [int];
  logic [31:0] mc_data [int];
`endif

  function automatic logic [31:0] word_at(logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ak;
      ak = a + 32'(k);
      w[8*k +: 8] = ram[ak[11:0]];
    end
    return w;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_mode = 0; m_got = 1'b0; m_inst = 32'd0; m_mem_a = 32'd0;
      m_base = 32'd0; m_restart = 1'b0; m_bytes.delete();
`ifdef ICACHE_EN
      mc_addr.delete(); mc_data.delete();
`endif
    end else if (!rdy) begin
      m_got = 1'b0;
      if (m_mode == 1) m_restart = 1'b1;
    end else if (bus.if_jump) begin
      m_got = 1'b0; m_mode = 0; m_bytes.delete(); m_restart = 1'b0;
    end else if (m_restart) begin
      m_got = 1'b0; m_bytes.delete(); m_mem_a = m_base; m_restart = 1'b0;
    end else begin
      m_got = 1'b0;
      if (m_mode == 0) begin
        if (bus.if_output_pc) begin
          logic [31:0] p;
          bit hit;
          p = bus.pc_to_getInst;
          m_base = p;
          hit = 1'b0;
`ifdef ICACHE_EN
          begin
            int li;
            li = int'((p >> 2) % 32'(LINES));
            if (p[1:0] == 2'b00 && mc_addr.exists(li) && mc_addr[li] == p) begin
              hit = 1'b1; m_inst = mc_data[li]; m_got = 1'b1; m_mode = 2;
            end
          end
`endif
          if (!hit) begin
            m_mem_a = p; m_bytes.delete(); m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        m_bytes.push_back(ram[m_mem_a[11:0]]);
        if (m_bytes.size() == 4) begin
          m_inst = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_got = 1'b1; m_mode = 2;
`ifdef ICACHE_EN
          if (m_base[1:0] == 2'b00) begin
            int li;
            li = int'((m_base >> 2) % 32'(LINES));
            mc_addr[li] = m_base; mc_data[li] = m_inst;
          end
`endif
        end else begin
          m_mem_a = m_base + 32'(m_bytes.size());
        end
      end else begin
        if (!bus.if_output_pc) m_mode = 0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_got", 32'(bus.if_gotInst), 32'(m_got));
    check("model_inst", bus.inst_mem, m_inst);
    check("model_mem_a", bus.mem_a, m_mem_a);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 7)) << 2;
      1:       return (32'($urandom_range(0, 7)) << 2) + 32'h400;
      2:       return 32'($urandom);
      default: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    endcase
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];
  int pulses;
  int phase;
  int wait_n;

  initial begin
    vecs[0] = '{32'h0000_0200, 8'h37, 8'h12, 8'h00, 8'h00, 32'h0000_1237};
    vecs[1] = '{32'h0000_0301, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCC_BBAA};
    vecs[2] = '{32'hFFFF_FFFE, 8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211};
    vecs[3] = '{32'h0000_07FC, 8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF_00FF};

    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
    ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h10; ram[7] = 8'h00;
    ram[12'h100] = 8'h93; ram[12'h101] = 8'h00; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;

    // Reset
    rst = 1'b0; rdy = 1'b1;
    bus.if_output_pc = 1'b0; bus.pc_to_getInst = 32'd0; bus.if_jump = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_got", 32'(bus.if_gotInst), 32'd0);
      check("reset_inst", bus.inst_mem, 32'h0);
      check("reset_mem_a", bus.mem_a, 32'h0);
    end

    // Basic fetch from 0x4
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h4;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("basic_mem_a", bus.mem_a, 32'h4 + 32'(k));
      check("basic_no_early_pulse", 32'(bus.if_gotInst), 32'd0);
    end
    tick();
    check("basic_pulse", 32'(bus.if_gotInst), 32'd1);
    check("basic_inst", bus.inst_mem, 32'h0010_0513);

    // Hold with request still high
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hold_no_pulse", 32'(bus.if_gotInst), 32'd0);
      check("hold_mem_a", bus.mem_a, 32'h7);
    end
    check("hold_inst", bus.inst_mem, 32'h0010_0513);
    bus.if_output_pc = 1'b0; tick();
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h8;
    tick();
    check("hold_next_mem_a", bus.mem_a, 32'h8);
    tick(); tick(); tick(); tick();
    check("hold_next_pulse", 32'(bus.if_gotInst), 32'd1);
    check("hold_next_inst", bus.inst_mem, word_at(32'h8));
    bus.if_output_pc = 1'b0; tick();

    // Jump at E2 of a fetch from 0x10
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h10;
    tick(); tick();
    bus.if_jump = 1'b1; bus.pc_to_getInst = 32'h100;
    tick();
    check("jump_no_pulse", 32'(bus.if_gotInst), 32'd0);
    check("jump_inst_kept", bus.inst_mem, word_at(32'h8));
    bus.if_jump = 1'b0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) check("jump_refetch_mem_a", bus.mem_a, 32'h100);
      if (i == 4) check("jump_pulse_timing", 32'(bus.if_gotInst), 32'd1);
      if (bus.if_gotInst) pulses++;
    end
    check("jump_pulse_count", 32'(pulses), 32'd1);
    check("jump_inst", bus.inst_mem, 32'h0010_0093);
    bus.if_output_pc = 1'b0; tick();

    // rdy gap after E2 of a fetch from 0x20
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h20;
    tick(); tick(); tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    check("rdy_frozen_mem_a", bus.mem_a, 32'h22);
    rdy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) check("rdy_restart_mem_a", bus.mem_a, 32'h20);
      if (bus.if_gotInst) pulses++;
    end
    check("rdy_pulse_count", 32'(pulses), 32'd1);
    check("rdy_inst", bus.inst_mem, word_at(32'h20));
    bus.if_output_pc = 1'b0; tick();

    // Vector table
    for (int v = 0; v < 4; v++) begin
      logic [31:0] a;
      a = vecs[v].pc;
      ram[a[11:0]] = vecs[v].b0; a = a + 32'd1;
      ram[a[11:0]] = vecs[v].b1; a = a + 32'd1;
      ram[a[11:0]] = vecs[v].b2; a = a + 32'd1;
      ram[a[11:0]] = vecs[v].b3;
      bus.if_output_pc = 1'b1; bus.pc_to_getInst = vecs[v].pc;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("vec_mem_a", bus.mem_a, vecs[v].pc + 32'(k));
      end
      tick();
      check("vec_pulse", 32'(bus.if_gotInst), 32'd1);
      check("vec_inst", bus.inst_mem, vecs[v].exp);
      bus.if_output_pc = 1'b0; tick();
    end

`ifdef ICACHE_EN
    // Cache hit, conflicting eviction, then miss again
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h40;
    for (int i = 0; i < 6; i++) tick();
    bus.if_output_pc = 1'b0; tick();
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h40;
    tick();
    check("cache_hit_pulse", 32'(bus.if_gotInst), 32'd1);
    check("cache_hit_mem_a", bus.mem_a, 32'h43);
    check("cache_hit_inst", bus.inst_mem, word_at(32'h40));
    bus.if_output_pc = 1'b0; tick();
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h40 + 32'(4 * LINES);
    tick();
    check("cache_conflict_miss", 32'(bus.if_gotInst), 32'd0);
    check("cache_conflict_mem_a", bus.mem_a, 32'h40 + 32'(4 * LINES));
    tick(); tick(); tick(); tick();
    check("cache_conflict_inst", bus.inst_mem, word_at(32'h40 + 32'(4 * LINES)));
    bus.if_output_pc = 1'b0; tick();
    bus.if_output_pc = 1'b1; bus.pc_to_getInst = 32'h40;
    tick();
    check("cache_evicted_miss", 32'(bus.if_gotInst), 32'd0);
    check("cache_evicted_mem_a", bus.mem_a, 32'h40);
    tick(); tick(); tick(); tick();
    check("cache_evicted_pulse", 32'(bus.if_gotInst), 32'd1);
    bus.if_output_pc = 1'b0; tick();
`endif

    // Random traffic against the model
    phase = 0; wait_n = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 599) != 0);
      bus.if_jump = ($urandom_range(0, 24) == 0);
      if (bus.if_jump) bus.pc_to_getInst = pick_pc();
      case (phase)
        0: begin
          if (wait_n == 0) begin
            bus.if_output_pc = 1'b1; bus.pc_to_getInst = pick_pc(); phase = 1;
          end else begin
            bus.if_output_pc = 1'b0; wait_n--;
          end
        end
        1: bus.if_output_pc = 1'b1;
        default: begin
          if (wait_n == 0) begin
            bus.if_output_pc = 1'b0; phase = 0; wait_n = $urandom_range(0, 2);
          end else begin
            wait_n--;
          end
        end
      endcase
      tick();
      if (phase == 1 && m_got) begin
        phase = 2; wait_n = $urandom_range(0, 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Responder side of the instruction-fetch handshake. The pc unit raises a fetch request with an address; this block answers with a 32-bit instruction and a one-cycle done pulse.
- Reads four bytes from the byte-wide RAM port and assembles them little-endian.
- Honours flush requests from the rob.
- Sits between the pc unit and the RAM byte port, inside mem_control.

Parameters:
- ADDR_WIDTH, 32, address width of pc request and RAM address.
- INST_WIDTH, 32, instruction width; always four bytes.
- ICACHE_LINES, 256, number of cache words; power of two; used only with ICACHE_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; reset applies at a clk edge while rst==0.
- rdy  in  1  global enable; state frozen while 0 (see Behaviour).
- if_output_pc  in  1  fetch request, level; held high by pc until it consumes the result.
- pc_to_getInst  in  ADDR_WIDTH  fetch address; sampled when a request is accepted.
- if_gotInst  out  1  one-cycle pulse: inst_mem valid.
- inst_mem  out  INST_WIDTH  fetched instruction; holds until the next completion.
- if_jump  in  1  flush from rob; aborts any fetch in progress.
- mem_din  in  8  RAM read byte; valid one cycle after mem_a is presented.
- mem_a  out  ADDR_WIDTH  RAM byte address.

Behaviour:
- Reset (rst==0 at edge): state=IDLE, if_gotInst=0, inst_mem=0, mem_a=0, byte counter=0, partial word=0. Takes effect mid-fetch with no pulse.
- rdy==0: no state, counter or output change, except if_gotInst is forced to 0. If rdy drops while in READ, set restart flag; on the first rdy==1 edge, reissue byte 0 and discard partial bytes.
- States: IDLE, READ, HOLD.
- IDLE:
  - If if_output_pc==1 and if_jump==0: latch base=pc_to_getInst, mem_a<=base, cnt<=0, go to READ. This is edge E0.
- READ:
  - At edge Ek (k=1..4), capture mem_din into byte k-1 of the partial word.
  - For k<4, mem_a<=base+k. Address arithmetic is mod 2^ADDR_WIDTH; 0xFFFFFFFF+1 wraps to 0.
  - At E4: inst_mem<={b3,b2,b1,b0} (b0 from base), if_gotInst<=1 for exactly one cycle, go to HOLD.
  - Latency: request accepted at E0, pulse visible after E4.
- HOLD:
  - Stay while if_output_pc==1.
  - Go to IDLE on the first edge where if_output_pc==0.
  - Never re-fetch while the request stays asserted; the pc may keep it high while its station is busy.
- Default outputs: if_gotInst is 0 on every edge unless set above. mem_a holds its last value when not fetching.
- if_jump==1 at any edge (rdy==1), any state: go to IDLE, no pulse, discard partial word, inst_mem unchanged. The request is not accepted at that edge; the new address is accepted at the next edge when if_output_pc==1.
- Simultaneous if_jump and the E4 capture: the jump wins; no pulse, inst_mem unchanged.
- Simultaneous rst==0 with anything: reset wins.

Optional Feature:
- Macro: ICACHE_EN.
- Defined: direct-mapped instruction cache with ICACHE_LINES words.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = the remaining upper bits; one valid bit per line.
  - At acceptance in IDLE, look up pc_to_getInst combinationally.
    - Hit: inst_mem<=cached word, if_gotInst pulse visible after E0, go to HOLD, no mem_a change.
    - Miss: run the normal READ sequence; at E4 write the word, tag and valid bit.
  - Reset clears all valid bits. if_jump does not invalidate.
  - Misaligned pc (pc[1:0]!=0) always misses and is never filled.
- Undefined: no cache storage; every request takes the four-byte READ path.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> if_gotInst=0, inst_mem=0x00000000, mem_a=0x0, no activity with if_output_pc=0.
- Basic fetch: pc=0x4, RAM[4..7]=13,05,10,00 -> mem_a sequence 4,5,6,7; inst_mem=0x00100513; single if_gotInst pulse after E4.
- Hold: keep if_output_pc=1 for 6 cycles after the pulse -> no new mem_a traffic, inst_mem stays 0x00100513; drop for 1 cycle, raise with pc=0x8 -> fetch from 0x8.
- Jump: if_jump=1 at E2 of fetch 0x10, pc_to_getInst=0x100 -> no pulse; next fetch reads 0x100..0x103 and returns RAM[0x100..0x103].
- rdy gap: rdy=0 for 3 cycles after E2 of fetch 0x20 -> refetch from 0x20 after resume; correct word; exactly one pulse.
- ICACHE_EN: fetch 0x40 twice -> second pulse after E0 with no mem_a change. Fetch 0x40+4*ICACHE_LINES -> miss, line evicted; refetch 0x40 -> miss again.
